// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared constants for the VGA scanout block: default 640x480@60
//            timing, derived totals, downscaled frame-buffer width, pipeline
//            latency and the default grayscale colour-index expansion.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default horizontal timing in pixel clocks
  localparam int c_h_visible = 640;
  localparam int c_h_fp      = 16;
  localparam int c_h_sync    = 96;
  localparam int c_h_bp      = 48;
  localparam int c_h_total   = c_h_visible + c_h_fp + c_h_sync + c_h_bp;

  // Default vertical timing in lines
  localparam int c_v_visible = 480;
  localparam int c_v_fp      = 10;
  localparam int c_v_sync    = 2;
  localparam int c_v_bp      = 33;
  localparam int c_v_total   = c_v_visible + c_v_fp + c_v_sync + c_v_bp;

  // Default block scaling and stored-line width
  localparam int c_scale_shift = 2;
  localparam int c_fb_width    = c_h_visible >> c_scale_shift;

  // Counter value to pin latency in clocks
  localparam int c_pipe_latency = 3;

  // Replicate the dw-bit index from the MSB down until rw bits are filled,
  // e.g. 2-bit 01 -> 4-bit 0101. Result is right-aligned in 16 bits.
  function automatic logic [15:0] grayscale(input logic [7:0] idx,
                                            input int dw,
                                            input int rw);
    logic [15:0] res;
    logic [7:0]  t;
    res = '0;
    for (int j = 0; j < 16; j++) begin
      if (j < rw) begin
        t   = idx >> (dw - 1 - (j % dw));
        res = {res[14:0], t[0]};
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Free-running horizontal/vertical counters with raw (undelayed)
//            sync, visible flag, line/frame end strobes and frame_done.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = c_h_visible,
  parameter int H_FP      = c_h_fp,
  parameter int H_SYNC    = c_h_sync,
  parameter int H_BP      = c_h_bp,
  parameter int V_VISIBLE = c_v_visible,
  parameter int V_FP      = c_v_fp,
  parameter int V_SYNC    = c_v_sync,
  parameter int V_BP      = c_v_bp,
  parameter int H_W       = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP),
  parameter int V_W       = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP)
)(
  input  logic           clk,
  input  logic           rst_n,
  output logic [H_W-1:0] o_h_cnt,
  output logic [V_W-1:0] o_v_cnt,
  output logic           o_line_end,
  output logic           o_frame_end,
  output logic           o_visible,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_frame_done
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] c_h_last    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] c_h_vis     = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] c_hs_start  = H_W'(H_VISIBLE + H_FP);
  localparam logic [H_W-1:0] c_hs_end    = H_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] c_v_last    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] c_v_vis     = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] c_vs_start  = V_W'(V_VISIBLE + V_FP);
  localparam logic [V_W-1:0] c_vs_end    = V_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;
  logic           w_line_end;
  logic           w_frame_end;

  assign w_line_end  = (r_h_cnt == c_h_last);
  assign w_frame_end = w_line_end && (r_v_cnt == c_v_last);

  // Pixel counter wraps each line; line counter advances on wrap, wraps per frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_frame_end ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt      = r_h_cnt;
  assign o_v_cnt      = r_v_cnt;
  assign o_line_end   = w_line_end;
  assign o_frame_end  = w_frame_end;
  assign o_visible    = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
  assign o_hsync      = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
  assign o_vsync      = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
  // Undelayed so the frame writer sees blanking start as early as possible
  assign o_frame_done = (r_h_cnt == '0) && (r_v_cnt == c_v_vis);

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Purpose  : Frame-buffer read-side scanout. Walks the downscaled buffer in
//            step with VGA timing, absorbs the RAM's 1-cycle read latency and
//            drives colour/sync pins with a fixed 3-cycle latency.
//            Optional: VGA_SCANOUT_PALETTE_EN adds a writable palette
//            (pal_we/pal_idx/pal_data); otherwise a fixed grayscale map.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH  = 2,
  parameter int ADDR_WIDTH  = 15,
  parameter int SCALE_SHIFT = c_scale_shift,
  parameter int RGB_WIDTH   = 4,
  parameter int H_VISIBLE   = c_h_visible,
  parameter int H_FP        = c_h_fp,
  parameter int H_SYNC      = c_h_sync,
  parameter int H_BP        = c_h_bp,
  parameter int V_VISIBLE   = c_v_visible,
  parameter int V_FP        = c_v_fp,
  parameter int V_SYNC      = c_v_sync,
  parameter int V_BP        = c_v_bp
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  q,
`ifdef VGA_SCANOUT_PALETTE_EN
  input  logic                   pal_we,
  input  logic [DATA_WIDTH-1:0]  pal_idx,
  input  logic [3*RGB_WIDTH-1:0] pal_data,
`endif
  output logic [ADDR_WIDTH-1:0]  read_addr,
  output logic [RGB_WIDTH-1:0]   vga_r,
  output logic [RGB_WIDTH-1:0]   vga_g,
  output logic [RGB_WIDTH-1:0]   vga_b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic                   frame_done
);

  localparam int H_W      = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam int V_W      = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam int FB_WIDTH = H_VISIBLE >> SCALE_SHIFT;

  localparam logic [V_W-1:0]        c_blk_mask = V_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] c_fb_step  = ADDR_WIDTH'(FB_WIDTH);

  logic [H_W-1:0]         w_h_cnt;
  logic [V_W-1:0]         w_v_cnt;
  logic                   w_line_end;
  logic                   w_frame_end;
  logic                   w_visible;
  logic                   w_hsync;
  logic                   w_vsync;
  logic [ADDR_WIDTH-1:0]  w_col;
  logic [3*RGB_WIDTH-1:0] w_lut;

  logic [ADDR_WIDTH-1:0]  r_row_base;
  logic [ADDR_WIDTH-1:0]  r_read_addr;
  logic                   r_hs1, r_vs1, r_de1;
  logic                   r_hs2, r_vs2, r_de2;
  logic                   r_hsync, r_vsync, r_de;
  logic [3*RGB_WIDTH-1:0] r_rgb;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .H_W       (H_W),
    .V_W       (V_W)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_h_cnt      (w_h_cnt),
    .o_v_cnt      (w_v_cnt),
    .o_line_end   (w_line_end),
    .o_frame_end  (w_frame_end),
    .o_visible    (w_visible),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_frame_done (frame_done)
  );

  assign w_col = ADDR_WIDTH'(w_h_cnt >> SCALE_SHIFT);

  // Row base steps one stored line after the last screen line of each block
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_base <= '0;
    end else if (w_frame_end) begin
      r_row_base <= '0;
    end else if (w_line_end && ((w_v_cnt & c_blk_mask) == c_blk_mask)) begin
      r_row_base <= r_row_base + c_fb_step;
    end
  end

  // Stage 1: registered RAM address plus sync/de delay
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_read_addr <= '0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
      r_de1       <= 1'b0;
    end else begin
      r_read_addr <= w_visible ? (r_row_base + w_col) : '0;
      r_hs1       <= w_hsync;
      r_vs1       <= w_vsync;
      r_de1       <= w_visible;
    end
  end

  // Stage 2: sync/de wait while the RAM returns q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
      r_de2 <= 1'b0;
    end else begin
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_de2 <= r_de1;
    end
  end

`ifdef VGA_SCANOUT_PALETTE_EN
  logic [3*RGB_WIDTH-1:0] r_pal [2**DATA_WIDTH];

  // Palette register file, reset to the grayscale ramp; lookup reads old entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**DATA_WIDTH; i++) begin
        r_pal[i] <= {3{RGB_WIDTH'(grayscale(8'(i), DATA_WIDTH, RGB_WIDTH))}};
      end
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_data;
    end
  end

  assign w_lut = r_pal[q];
`else
  assign w_lut = {3{RGB_WIDTH'(grayscale(8'(q), DATA_WIDTH, RGB_WIDTH))}};
`endif

  // Stage 3: colour lookup and aligned pins; colour blanked outside de
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
    end else begin
      r_rgb   <= r_de2 ? w_lut : '0;
      r_hsync <= r_hs2;
      r_vsync <= r_vs2;
      r_de    <= r_de2;
    end
  end

  assign read_addr = r_read_addr;
  assign vga_r     = r_rgb[3*RGB_WIDTH-1:2*RGB_WIDTH];
  assign vga_g     = r_rgb[2*RGB_WIDTH-1:RGB_WIDTH];
  assign vga_b     = r_rgb[RGB_WIDTH-1:0];
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign de        = r_de;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Purpose  : Scoreboard bench for vga_scanout. A reference model derives the
//            expected pins from elapsed cycles since reset using plain
//            arithmetic; a monitor pops and compares every cycle. Timing is
//            scaled down so whole frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

  localparam int DW  = 2;
  localparam int AW  = 15;
  localparam int SS  = 2;
  localparam int RW  = 4;
  localparam int HV  = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VV  = 24, VFP = 2, VS = 2, VBP = 2;
  localparam int HT    = HV + HFP + HS + HBP;
  localparam int VT    = VV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int FBW   = HV >> SS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     q;
  logic [AW-1:0]     read_addr;
  logic [RW-1:0]     vga_r, vga_g, vga_b;
  logic              hsync, vsync, de, frame_done;
`ifdef VGA_SCANOUT_PALETTE_EN
  logic              pal_we;
  logic [DW-1:0]     pal_idx;
  logic [3*RW-1:0]   pal_data;
`endif

  always #5 clk = ~clk;

  vga_scanout #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCALE_SHIFT(SS), .RGB_WIDTH(RW),
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q          (q),
`ifdef VGA_SCANOUT_PALETTE_EN
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_data   (pal_data),
`endif
    .read_addr  (read_addr),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .frame_done (frame_done)
  );

  // Frame buffer RAM with one cycle registered read
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) q <= mem[read_addr];

  typedef struct {
    int n;
    int addr;
    bit hs;
    bit vs;
    bit de;
    bit fd;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t          sb_q[$];
  int            n_now    = 0;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [3*RW-1:0] pal_m [1 << DW];

  // Buffer word shown at counter position m (elapsed cycles since reset)
  function automatic int pix_addr(input int m);
    int h, v;
    h = m % HT;
    v = (m / HT) % VT;
    if (h < HV && v < VV) return (v >> SS) * FBW + (h >> SS);
    return 0;
  endfunction

  // Grayscale ramp: index scaled linearly to full channel range
  function automatic logic [3*RW-1:0] gray_rgb(input int idx);
    int g;
    g = idx * ((1 << RW) - 1) / ((1 << DW) - 1);
    return {RW'(g), RW'(g), RW'(g)};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v, input int n);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp_v);
    end
  endtask

  // Reference model: one expected record per cycle after the first reset edge
  initial begin : model
    bit              synced;
    exp_t            e;
    int              m, h, v;
    logic [3*RW-1:0] col;
    synced = 1'b0;
    for (int i = 0; i < (1 << DW); i++) pal_m[i] = gray_rgb(i);
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        synced = 1'b1;
        n_now  = 0;
        for (int i = 0; i < (1 << DW); i++) pal_m[i] = gray_rgb(i);
      end else if (synced) begin
        n_now++;
      end
      if (synced) begin
        e.n    = n_now;
        e.addr = (n_now >= 1) ? pix_addr(n_now - 1) : 0;
        if (n_now >= 3) begin
          m    = n_now - 3;
          h    = m % HT;
          v    = (m / HT) % VT;
          e.de = (h < HV) && (v < VV);
          e.hs = !((h >= HV + HFP) && (h < HV + HFP + HS));
          e.vs = !((v >= VV + VFP) && (v < VV + VFP + VS));
          col  = e.de ? pal_m[mem[pix_addr(m)]] : '0;
        end else begin
          e.de = 1'b0;
          e.hs = 1'b1;
          e.vs = 1'b1;
          col  = '0;
        end
        e.r  = int'(col[3*RW-1:2*RW]);
        e.g  = int'(col[2*RW-1:RW]);
        e.b  = int'(col[RW-1:0]);
        e.fd = ((n_now % FRAME) == VV * HT);
        sb_q.push_back(e);
`ifdef VGA_SCANOUT_PALETTE_EN
        if (rst_n && pal_we) pal_m[pal_idx] = pal_data;
`endif
      end
    end
  end

  // Monitor: compare DUT pins against the oldest expected record
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("read_addr",  32'(read_addr),  32'(e.addr), e.n);
        check("hsync",      32'(hsync),      32'(e.hs),   e.n);
        check("vsync",      32'(vsync),      32'(e.vs),   e.n);
        check("de",         32'(de),         32'(e.de),   e.n);
        check("vga_r",      32'(vga_r),      32'(e.r),    e.n);
        check("vga_g",      32'(vga_g),      32'(e.g),    e.n);
        check("vga_b",      32'(vga_b),      32'(e.b),    e.n);
        check("frame_done", 32'(frame_done), 32'(e.fd),   e.n);
      end
    end
  end

  task automatic run_cycles(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
`ifdef VGA_SCANOUT_PALETTE_EN
      pal_we   = ($urandom_range(63, 0) == 0);
      pal_idx  = DW'($urandom);
      pal_data = (3*RW)'($urandom);
`endif
    end
`ifdef VGA_SCANOUT_PALETTE_EN
    pal_we = 1'b0;
`endif
  endtask

  initial begin : driver
    bit found;
    int fd_cnt;
    rst_n = 1'b0;
`ifdef VGA_SCANOUT_PALETTE_EN
    pal_we   = 1'b0;
    pal_idx  = '0;
    pal_data = '0;
`endif
    for (int i = 0; i < (2**AW); i++) mem[i] = DW'($urandom);

    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    run_cycles(2 * FRAME + 300);

`ifdef VGA_SCANOUT_PALETTE_EN
    @(negedge clk);
    pal_we   = 1'b1;
    pal_idx  = 2'd2;
    pal_data = 12'hF00;
    @(negedge clk);
    pal_we   = 1'b0;
    run_cycles(FRAME);
`endif

    // Reset mid-frame at counter (30,10)
    found = 1'b0;
    for (int k = 0; k < FRAME + 10 && !found; k++) begin
      @(negedge clk);
      if ((n_now % FRAME) == 10 * HT + 30) found = 1'b1;
    end
    check("mid_reset_reached", 32'(found), 32'd1, n_now);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fd_cnt = -1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) begin
        fd_cnt = k;
        break;
      end
    end
    check("frame_done_after_reset", 32'(fd_cnt), 32'(VV * HT), n_now);

    // Random reset pulses at random points
    repeat (6) begin
      run_cycles($urandom_range(1500, 50));
      rst_n = 1'b0;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      rst_n = 1'b1;
    end

    run_cycles(FRAME + 50);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scanout.md
# vga_scanout

Read-side consumer of the dual-port frame buffer RAM: generates 640x480@60 VGA timing, issues `read_addr` into the downscaled buffer (one stored pixel per SCALE x SCALE screen block, 160x120 = 19200 words by default), absorbs the RAM's 1-cycle registered read latency, and drives colour and sync pins. It sits between the frame buffer's read port and the board's VGA DAC/resistor network. It runs on the same clock as the RAM read port.

## Interface
- DATA_WIDTH, 2, frame buffer word width (colour index)
- ADDR_WIDTH, 15, frame buffer address width
- SCALE_SHIFT, 2, log2 of block size (4x4 screen pixels per stored pixel)
- RGB_WIDTH, 4, bits per colour channel
- H_VISIBLE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks (total 800)
- V_VISIBLE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)
- clk  in  1  pixel clock, one pixel per cycle; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- q  in  DATA_WIDTH  RAM read data, valid 1 cycle after `read_addr` is sampled by the RAM
- read_addr  out  ADDR_WIDTH  RAM read address (registered)
- vga_r, vga_g, vga_b  out  RGB_WIDTH each  colour, zero outside visible area
- hsync, vsync  out  1  active-low sync
- de  out  1  high during visible pixels
- frame_done  out  1  one-cycle pulse when counters enter line V_VISIBLE, pixel 0 (start of vertical blank)

## Operation
- Stage 0: h_cnt 0..799, v_cnt 0..524; h wraps to 0 and v increments at h=799; v wraps to 0 at (799,524).
- Address: no multiplier. col = h_cnt>>SCALE_SHIFT; row_base += FB_WIDTH (=H_VISIBLE>>SCALE_SHIFT) at end of each line where (v_cnt & (2^SCALE_SHIFT-1)) == 2^SCALE_SHIFT-1; row_base clears at frame wrap. Stage 1 registers read_addr = row_base+col when (h,v) visible, else 0.
- Stage 2: RAM returns q. Stage 3: registered colour lookup, hsync, vsync, de; colour forced to 0 when de=0.
- hsync low for H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC; vsync likewise on v_cnt. de = h<H_VISIBLE && v<V_VISIBLE. Sync/de delayed through stages 1-3 so all pins align with colour.
- Reset (any cycle, including mid-frame): counters, row_base, pipelines cleared; read_addr=0, colour=0, hsync=1, vsync=1, de=0, frame_done=0. First post-reset cycle has counters at (0,0).

## Timing
- Counter value (h,v) at cycle t -> read_addr at t+1 -> q at t+2 -> pins at t+3. Fixed 3-cycle latency, no stalls, no handshake.
- Per line: 800 clocks; hsync low 96 clocks starting 656 clocks after de rises. Per frame: 420000 clocks.
- Last visible pixel (639,479) -> read_addr 19199. frame_done asserted in stage-0 timing (not delayed) so the writer gets maximal blanking time.

## Configuration
- VGA_SCANOUT_PALETTE_EN defined: adds ports pal_we (in,1), pal_idx (in,DATA_WIDTH), pal_data (in,3*RGB_WIDTH, {r,g,b}); 2^DATA_WIDTH-entry palette register file, reset to grayscale defaults; write visible on pins from the stage-3 lookup in the cycle after the write edge; lookup coincident with write uses old entry.
- Undefined: fixed grayscale map, index bits replicated to fill each channel (2-bit: 00->0000, 01->0101, 10->1010, 11->1111); no palette ports.

## Structure
- Package vga_pkg: default timing constants, derived totals (H_TOTAL, V_TOTAL), FB_WIDTH, pipeline latency constant (3), grayscale default function.
- Sub-module vga_timing: h/v counters, raw sync/de, frame_done, visible flag. Address generation, pipeline and colour mapping stay in vga_scanout.

## Test plan
- Reset: hold rst_n=0 10 cycles -> hsync=1, vsync=1, de=0, rgb=0, read_addr=0; release -> de rises exactly 3 cycles later.
- Line timing: measure -> de high 640, hsync falls 656 cycles after de rise, low 96, period 800; vsync low 2 lines starting 490 lines after frame start.
- Addressing: row 0 -> read_addr 0 for h 0..3, 1 for 4..7, 159 for 636..639; line 4 starts at 160; (639,479) -> 19199; next frame restarts at 0.
- Data path: RAM model with 1-cycle latency, word n = n%4 -> pin colour at each visible pixel equals grayscale(((v>>2)*160+(h>>2))%4); colour 0 during blank.
- Reset mid-frame at (300,200) -> outputs return to reset values next cycle; resumes at (0,0), frame_done next fires 480*800 cycles later.
- With VGA_SCANOUT_PALETTE_EN: write idx 2 = 12'hF00 -> pixels with q=2 show r=F,g=0,b=0 from the next lookup; others unchanged.
